// File: rtl/cnn_infer_sched.sv
// cnn_infer_sched: launches one FC classifier run at a time and publishes its one-hot decision.
// Optional CNN_ACT_DEBOUNCE_EN: publish only when two consecutive valid results agree.
module cnn_infer_sched #(
  parameter int DATA_W         = 16,
  parameter int IN_LENGTH      = 32,
  parameter int OUT_POINT      = 4,
  parameter int SETTLE_CYCLES  = 1,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  input  logic [DATA_W*IN_LENGTH-1:0]   req_data,
  output logic [DATA_W*IN_LENGTH-1:0]   fc_data_in,
  output logic                          fc_data_in_valid,
  input  logic                          fc_data_out_valid,
  input  logic [OUT_POINT-1:0]          fc_one_hot,
  output logic                          busy,
  output logic                          action_valid,
  output logic [1:0]                    action,
  output logic [OUT_POINT-1:0]          action_one_hot,
  input  logic                          err_clr,
  output logic                          timeout_err,
  output logic                          onehot_err,
  output logic [7:0]                    drop_cnt
);
  localparam int VW   = DATA_W*IN_LENGTH;
  localparam int WD_W = $clog2(TIMEOUT_CYCLES+1);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_SETTLE, S_PUBLISH
  } state_t;

  state_t          state, state_nxt;
  logic [WD_W-1:0] wd_cnt;
  logic [2:0]      st_cnt;
  logic            slot_full;
  logic [VW-1:0]   slot_data;
  logic            oh_ok, accept, wd_exp, st_done, sample;
  logic            to_set, oh_set;
  logic [1:0]      oh_idx;
`ifdef CNN_ACT_DEBOUNCE_EN
  logic [OUT_POINT-1:0] cand;
`endif

  always_comb begin
    oh_ok = (fc_one_hot != '0) &&
            ((fc_one_hot & (fc_one_hot - OUT_POINT'(1))) == '0);
    oh_idx = '0;
    for (int i = 0; i < OUT_POINT; i++)
      if (fc_one_hot[i]) oh_idx = 2'(i);
    wd_exp  = wd_cnt == WD_W'(TIMEOUT_CYCLES - 1);
    st_done = st_cnt == 3'(SETTLE_CYCLES - 1);
    sample  = (state == S_SETTLE) && st_done;
`ifdef CNN_ACT_DEBOUNCE_EN
    accept  = oh_ok && (fc_one_hot == cand);
`else
    accept  = oh_ok;
`endif
    // done strobe beats the watchdog in the same cycle
    to_set  = (state == S_WAIT) && !fc_data_out_valid && wd_exp;
    oh_set  = sample && !oh_ok;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (slot_full || req_valid) state_nxt = S_LAUNCH;
      S_LAUNCH:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (fc_data_out_valid) state_nxt = S_SETTLE;
        else if (wd_exp)       state_nxt = S_IDLE;
      end
      S_SETTLE:  if (st_done) state_nxt = accept ? S_PUBLISH : S_IDLE;
      S_PUBLISH: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    fc_data_in_valid = state == S_LAUNCH;
    action_valid     = state == S_PUBLISH;
    busy             = state != S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fc_data_in     <= '0;
      slot_full      <= 1'b0;
      slot_data      <= '0;
      drop_cnt       <= '0;
      wd_cnt         <= '0;
      st_cnt         <= '0;
      action         <= '0;
      action_one_hot <= '0;
      timeout_err    <= 1'b0;
      onehot_err     <= 1'b0;
`ifdef CNN_ACT_DEBOUNCE_EN
      cand           <= '0;
`endif
    end else begin
      if (state == S_IDLE) begin
        // a draining slot launches first; a concurrent request refills it
        if (slot_full) begin
          fc_data_in <= slot_data;
          slot_full  <= req_valid;
          if (req_valid) slot_data <= req_data;
        end else if (req_valid) begin
          fc_data_in <= req_data;
        end
      end else if (req_valid) begin
        slot_full <= 1'b1;
        slot_data <= req_data;
        if (slot_full && drop_cnt != 8'hff)
          drop_cnt <= drop_cnt + 8'd1;
      end
      if (state == S_LAUNCH)    wd_cnt <= '0;
      else if (state == S_WAIT) wd_cnt <= wd_cnt + WD_W'(1);
      if (state == S_WAIT)        st_cnt <= '0;
      else if (state == S_SETTLE) st_cnt <= st_cnt + 3'd1;
      if (sample && accept) begin
        action         <= oh_idx;
        action_one_hot <= fc_one_hot;
      end
`ifdef CNN_ACT_DEBOUNCE_EN
      if (sample && oh_ok) cand <= fc_one_hot;
`endif
      timeout_err <= to_set | (timeout_err & ~err_clr);
      onehot_err  <= oh_set | (onehot_err & ~err_clr);
    end
  end

endmodule

// File: doc/cnn_infer_sched.md
Name: cnn_infer_sched

Overview:
- Sequences the final fully-connected classifier stage (4 outputs, one-hot decision) for the in-game CNN player.
- Accepts feature-vector requests from the upstream layer and launches one classifier run at a time with a single-cycle valid pulse.
- Waits for the classifier's done strobe, lets its one-hot result settle, validates it, and publishes a registered action code to game logic.
- Provides a 1-deep pending slot, a watchdog timeout and error/drop statistics.

Parameters:
- DATA_W, 16, width of one feature word
- IN_LENGTH, 32, feature words per request
- OUT_POINT, 4, classifier outputs (one-hot width)
- SETTLE_CYCLES, 1, cycles from the done strobe to the one-hot sample (range 1..7)
- TIMEOUT_CYCLES, 256, maximum cycles in WAIT before abort (the classifier normally needs about 135)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  feature vector available (pulse or level; sampled every cycle)
- req_data  in  DATA_W*IN_LENGTH  feature vector
- fc_data_in  out  DATA_W*IN_LENGTH  vector to classifier; held stable from launch until the next launch
- fc_data_in_valid  out  1  one-cycle launch pulse
- fc_data_out_valid  in  1  classifier done strobe
- fc_one_hot  in  OUT_POINT  classifier decision
- busy  out  1  high in every state except IDLE
- action_valid  out  1  one-cycle pulse when new action is published
- action  out  2  encoded action: index of the set one-hot bit
- action_one_hot  out  OUT_POINT  registered copy of the accepted one-hot
- err_clr  in  1  clears sticky error flags
- timeout_err  out  1  sticky: watchdog expired
- onehot_err  out  1  sticky: sampled one-hot did not have exactly one bit set
- drop_cnt  out  8  saturating count of overwritten pending requests

Behaviour:
- Reset values: all outputs 0, and the state machine is in IDLE. The pending slot is empty and all counters are 0.
- States: IDLE, LAUNCH, WAIT, SETTLE, PUBLISH.
- IDLE:
  - If the pending slot is full, load fc_data_in from it, clear the slot, and go to LAUNCH.
  - Otherwise, if req_valid, load fc_data_in from req_data and go to LAUNCH.
- LAUNCH:
  - fc_data_in_valid = 1 for exactly this cycle.
  - Clear the watchdog counter and go to WAIT.
- WAIT:
  - The watchdog counter increments each cycle.
  - If fc_data_out_valid, go to SETTLE.
  - If the counter reaches TIMEOUT_CYCLES-1 without the done strobe, set timeout_err and go to IDLE. No action_valid is produced.
  - If the done strobe and the timeout fall in the same cycle, the done strobe wins.
- SETTLE:
  - Count SETTLE_CYCLES cycles, then sample fc_one_hot.
  - If the sample is valid one-hot, update action and action_one_hot and go to PUBLISH.
  - Otherwise set onehot_err, keep the previous action, and go to IDLE.
- PUBLISH: action_valid = 1 for this cycle, then go to IDLE.
- Latency: with the done strobe high in cycle k, action_valid is high in cycle k+SETTLE_CYCLES+1. With req_valid high in cycle 0 and IDLE, fc_data_in_valid is high in cycle 1.
- Pending slot:
  - req_valid while busy stores req_data into the slot.
  - If the slot is already full, it is overwritten with the newest data and drop_cnt increments, saturating at 255.
  - req_valid in the same IDLE cycle that drains the slot: the slot data launches, and the new request occupies the slot without a drop.
- fc_data_out_valid outside WAIT is ignored.
- err_clr clears timeout_err and onehot_err. If err_clr and a new error occur in the same cycle, the set wins.
- drop_cnt is cleared only by rst.
- Reset mid-run returns everything to reset values immediately, with no trailing fc_data_in_valid or action_valid. The classifier's own reset is assumed to be driven by the same source.

Optional Feature:
- Macro: CNN_ACT_DEBOUNCE_EN.
- When defined:
  - A valid result updates action/action_one_hot and pulses action_valid only if it equals the previous valid sampled one-hot, i.e. two consecutive agreeing results.
  - A disagreeing result is stored as the new candidate; the run returns to IDLE without action_valid.
  - The candidate resets to 0 on rst.
- When undefined: every valid result publishes.

Test Plan:
- Single request, classifier model done 133 cycles after launch, fc_one_hot=4'b0100 -> fc_data_in_valid one cycle after req; action=2, action_one_hot=4'b0100, action_valid one pulse exactly 2 cycles after done (SETTLE_CYCLES=1); busy low afterwards.
- Three req_valid pulses during one run with vectors A, B, C -> drop_cnt=1 and the second launch uses C. Repeat 300 times -> drop_cnt saturates at 255.
- Classifier never signals done -> timeout_err=1 exactly 256 cycles after WAIT entry, no action_valid, returns to IDLE; err_clr pulse clears it; a done strobe arriving later is ignored.
- fc_one_hot=4'b0110, then 4'b0000 -> onehot_err=1, action unchanged from the prior value (e.g. 1), no action_valid.
- rst asserted 50 cycles into WAIT with the slot full -> all outputs 0 the same cycle; no launch after release until a new req_valid.
- With CNN_ACT_DEBOUNCE_EN, results 0001, 1000, 1000 -> only the third run pulses action_valid, with action=3.
